// File: rtl/seq_mult_ctrl_pkg.sv
// mult_pkg: shared types and constants for the sequential shift-add multiplier.
//   state_t      - controller FSM states (IDLE, RUN, DONE)
//   N_MIN/N_MAX  - supported operand width range
package mult_pkg;

  localparam int N_MIN = 4;
  localparam int N_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/seq_mult_ctrl_if.sv
// seq_mult_ctrl_if: operand/result handshake bundle for seq_mult_ctrl.
//   start, signed_mode, A, B  - request side (driven by master)
//   out_ready                 - consumer accept (driven by master)
//   busy, out_valid, P        - status and product (driven by slave)
interface seq_mult_ctrl_if #(
  parameter int N = 8
);
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] P;

  modport master (
    output start, signed_mode, A, B, out_ready,
    input  busy, out_valid, P
  );

  modport slave (
    input  start, signed_mode, A, B, out_ready,
    output busy, out_valid, P
  );
endinterface : seq_mult_ctrl_if

// File: rtl/seq_mult_ctrl_datapath.sv
// mult_acc_datapath: shift-add datapath of the sequential multiplier.
// Holds operand magnitudes, the result sign, the 2N-bit accumulator and the
// product register.
//   clk, rst_n  - clock, async active-low reset
//   i_load      - capture operands, clear accumulator
//   i_step      - add partial product for bit i_cnt of |B|
//   i_last      - final step: load product register (sign applied)
//   i_signed    - operands are two's complement
//   i_a, i_b    - operands (sampled on i_load only)
//   i_cnt       - current multiplier bit index
//   o_p         - product register
module mult_acc_datapath #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic           i_last,
  input  logic           i_signed,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic [CW-1:0]  i_cnt,
  output logic [2*N-1:0] o_p
);

  logic [N-1:0]   r_mag_a;
  logic [N-1:0]   r_mag_b;
  logic           r_neg;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_p;

  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic [2*N-1:0] w_addend;
  logic [2*N-1:0] w_sum;
  logic [2*N-1:0] w_final;

  // Negating -2^(N-1) in N bits wraps back to the same pattern, which read
  // as unsigned is exactly the required magnitude 2^(N-1).
  assign w_mag_a = (i_signed && i_a[N-1]) ? -i_a : i_a;
  assign w_mag_b = (i_signed && i_b[N-1]) ? -i_b : i_b;

  // Max sum is (2^N-1)^2 < 2^(2N), so the 2N-bit accumulator never overflows.
  assign w_addend = r_mag_b[i_cnt] ? ({{N{1'b0}}, r_mag_a} << i_cnt) : '0;
  assign w_sum    = r_acc + w_addend;
  assign w_final  = r_neg ? -w_sum : w_sum;

  // NOTE: every datapath register is reset, not only control state, so an
  // aborted multiply leaves no residue and P reads 0 straight after reset.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_p     <= '0;
    end else begin
      if (i_load) begin
        r_mag_a <= w_mag_a;
        r_mag_b <= w_mag_b;
        r_neg   <= i_signed & (i_a[N-1] ^ i_b[N-1]);
        r_acc   <= '0;
      end else if (i_step) begin
        r_acc <= w_sum;
      end
      if (i_last) begin
        r_p <= w_final;
      end
    end
  end

  assign o_p = r_p;

endmodule : mult_acc_datapath

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential signed/unsigned N x N multiplier, one multiplier
// bit per clock, with a valid/ready result handshake.
//   clk    - clock, rising edge
//   rst_n  - async active-low reset
//   bus    - slave side of seq_mult_ctrl_if (start, signed_mode, A, B,
//            out_ready in; busy, out_valid, P out)
// A result appears exactly N edges after the accept edge and is held until
// consumed; a new request may be accepted on the consuming edge.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_mult_ctrl_if.slave  bus
);

  if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_width
    $error("seq_mult_ctrl: operand width N out of supported range");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_load;
  logic          w_step;
  logic          w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // start only counts on the edge that also consumes the result.
        if (bus.out_ready) begin
          if (bus.start) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_step) r_cnt <= r_cnt + CW'(1);
  end

  mult_acc_datapath #(
    .N  (N),
    .CW (CW)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_last   (w_last),
    .i_signed (bus.signed_mode),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_cnt    (r_cnt),
    .o_p      (bus.P)
  );

  assign bus.busy      = (r_state == RUN);
  assign bus.out_valid = (r_state == DONE);

endmodule : seq_mult_ctrl

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits, legal range 4..32.
REQ-002 SHALL have parameter CW, default $clog2(N): bit-counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  request to begin a multiply.
REQ-006 SHALL have port signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port A  in  N  multiplicand.
REQ-008 SHALL have port B  in  N  multiplier.
REQ-009 SHALL have port busy  out  1  high while a multiply is in progress.
REQ-010 SHALL have port out_valid  out  1  P holds a valid result.
REQ-011 SHALL have port out_ready  in  1  consumer accepts P.
REQ-012 SHALL have port P  out  2N  product.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, the rising edge SHALL capture A, B and signed_mode, clear the accumulator and counter, and enter RUN; busy=1 from that edge.
REQ-015 Signed mode: capture SHALL register |A|, |B| as N-bit unsigned magnitudes and neg = A[N-1] XOR B[N-1]; -2^(N-1) maps to magnitude 2^(N-1).
REQ-016 Unsigned mode: capture SHALL register A and B unchanged, with neg=0.
REQ-017 Each RUN cycle with counter=i SHALL add (magnitude_A << i) into the 2N-bit accumulator when bit i of magnitude_B is 1, then increment the counter.
REQ-018 Accumulator arithmetic SHALL be 2N bits, unsigned, with no carry-out loss for any legal operand pair.
REQ-019 On the RUN edge with counter=N-1, P SHALL load the final sum (two's-complement negated if neg=1); state SHALL go to DONE, busy=0 and out_valid=1.
REQ-020 Latency SHALL be exactly N clock edges from the accept edge to out_valid=1.
REQ-021 In DONE, P and out_valid SHALL hold until out_ready=1; the edge with out_ready=1 SHALL clear out_valid.
REQ-022 Without start on that edge, the FSM SHALL go DONE->IDLE.
REQ-023 In DONE, out_ready=1 and start=1 on the same edge SHALL consume the result and accept the new operands (back-to-back), entering RUN.
REQ-024 start SHALL be ignored in RUN, and in DONE while out_ready=0; operand inputs are don't-care outside the accept edge.
REQ-025 P SHALL retain its last value after consumption until the next result load.
REQ-026 Signed result of -2^(N-1) * -2^(N-1) SHALL be +2^(2N-2), representable in 2N bits.

Reset
REQ-027 rst_n=0 SHALL immediately, regardless of clock, force state=IDLE, busy=0, out_valid=0, P=0, accumulator=0, counter=0, neg=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no result produced; the first start after rst_n rises SHALL behave as from power-up.

Structure
REQ-029 Package mult_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the range constants N_MIN=4, N_MAX=32.
REQ-030 The shift-add datapath (magnitude registers, accumulator, conditional add, final negation) SHALL be one sub-module, mult_acc_datapath, parametrised by N; FSM and handshake SHALL stay in seq_mult_ctrl.
REQ-031 Implementation SHALL contain no combinational N-by-N multiplier operator.

Verification (N=8)
REQ-032 Unsigned: A=13, B=11, start one cycle -> out_valid rises exactly 8 edges after the accept edge, P=143.
REQ-033 Signed: A=-128 (0x80), B=-128 -> P=16384 (0x4000); A=-3 (0xFD), B=7 -> P=-21 (0xFFEB); unsigned A=255, B=255 -> P=65025.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> P and out_valid stable; start pulses during RUN and during DONE with out_ready=0 are ignored.
REQ-035 Back-to-back: in DONE drive out_ready=1 and start=1 with A=2, B=3 -> previous result consumed, busy=1 next cycle, P=6 after 8 edges.
REQ-036 Reset: assert rst_n=0 at counter=4 of A=100, B=100 -> all outputs 0 immediately; after release, A=100, B=100 -> P=10000.
REQ-037 Zero operand: A=0, B=200 -> P=0 after 8 edges; A=1, B=0 -> P=0.
